// File: rtl/sdf_r2_stage.sv
// sdf_r2_stage: radix-2 SDF DIF FFT stage with internal sequencing, twiddle multiply, round and saturate.
//   in_valid/in_sof/in_re/in_im : input samples, in_sof marks the first sample of a frame
//   tw_k/tw_re/tw_im            : twiddle ROM index out, twiddle value back in the same cycle
//   out_valid/out_re/out_im     : results, two clocks after the accepted input
module sdf_r2_stage #(
  parameter int WIDTH = 16,
  parameter int LOG2_D = 2,
  parameter int TW_W = 16,
  localparam int KW = (LOG2_D > 0) ? LOG2_D : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [WIDTH-1:0]      in_re,
  input  logic [WIDTH-1:0]      in_im,
  output logic [KW-1:0]         tw_k,
  input  logic [TW_W-1:0]       tw_re,
  input  logic [TW_W-1:0]       tw_im,
  output logic                  out_valid,
  output logic [WIDTH:0]        out_re,
  output logic [WIDTH:0]        out_im
);
  localparam int D = 1 << LOG2_D;
  localparam int AW = WIDTH + 1;
  localparam int PW = WIDTH + TW_W + 2;
  localparam logic [LOG2_D:0] KMASK = (LOG2_D + 1)'(D - 1);
  localparam logic [LOG2_D:0] DCNT = (LOG2_D + 1)'(D);
  localparam logic [LOG2_D:0] ONE = (LOG2_D + 1)'(1);
  localparam logic signed [PW-1:0] RND = PW'(1) << (TW_W - 3);
  logic [LOG2_D:0] cnt, c;
  logic primed, ph_b, byp;
  logic signed [AW-1:0] dl_re [D];
  logic signed [AW-1:0] dl_im [D];
  logic signed [AW-1:0] x_re, x_im, f_re, f_im, wr_re, wr_im, op_re, op_im;
  logic signed [AW-1:0] a_re, a_im;
  logic signed [TW_W-1:0] w_re, w_im;
  logic b1, v1;
  logic signed [PW-1:0] p_re, p_im;
  // an accepted start-of-frame sample is sequenced as count 0
  assign c = (in_valid & in_sof) ? '0 : cnt;
  assign ph_b = c[LOG2_D];
  assign tw_k = KW'(c & KMASK);
  assign byp = ph_b | (tw_k == '0);
  assign x_re = {in_re[WIDTH-1], in_re};
  assign x_im = {in_im[WIDTH-1], in_im};
  assign f_re = dl_re[D-1];
  assign f_im = dl_im[D-1];
  assign wr_re = ph_b ? f_re - x_re : x_re;
  assign wr_im = ph_b ? f_im - x_im : x_im;
  assign op_re = ph_b ? f_re + x_re : f_re;
  assign op_im = ph_b ? f_im + x_im : f_im;
  function automatic logic [AW-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] s;
    s = v >>> (TW_W - 2);
    return (&s[PW-1:WIDTH] | ~|s[PW-1:WIDTH]) ? s[AW-1:0] :
           (s[PW-1] ? {1'b1, {WIDTH{1'b0}}} : {1'b0, {WIDTH{1'b1}}});
  endfunction
  always_comb begin
    p_re = PW'(a_re) * PW'(w_re) - PW'(a_im) * PW'(w_im) + RND;
    p_im = PW'(a_re) * PW'(w_im) + PW'(a_im) * PW'(w_re) + RND;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      primed <= 1'b0;
      for (int i = 0; i < D; i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
    end else if (in_valid) begin
      cnt <= c + ONE;
      primed <= primed | (c == DCNT);
      dl_re[0] <= wr_re;
      dl_im[0] <= wr_im;
      for (int i = 1; i < D; i++) begin
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      b1 <= 1'b0;
      a_re <= '0;
      a_im <= '0;
      w_re <= '0;
      w_im <= '0;
      out_valid <= 1'b0;
      out_re <= '0;
      out_im <= '0;
    end else begin
      v1 <= in_valid & (primed | ph_b);
      b1 <= byp;
      a_re <= op_re;
      a_im <= op_im;
      w_re <= tw_re;
      w_im <= tw_im;
      out_valid <= v1;
      if (v1) begin
        out_re <= b1 ? a_re : sat(p_re);
        out_im <= b1 ? a_im : sat(p_im);
      end
    end
  end
endmodule

// File: doc/sdf_r2_stage.md
Name: sdf_r2_stage

Overview:
- Parametrised radix-2 single-path delay-feedback (SDF) DIF stage for the pipelined FFT datapath. One instance serves any stage: delay depth 2^LOG2_D.
- Integrates its own sample counter and butterfly/twiddle sequencing, replacing externally driven select lines.
- Adds a valid/start-of-frame handshake and a general complex twiddle multiply with rounding and saturation. The twiddle is fed from an external ROM indexed by this block.

Parameters:
- WIDTH, 16, input component width (signed two's complement).
- LOG2_D, 2, log2 of delay-line depth D; legal range 0..5 (D = 1..32).
- TW_W, 16, twiddle component width, signed Q2.(TW_W-2); 1.0 = 2^(TW_W-2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_sof  in  1  first sample of a frame; qualified by in_valid
- in_re  in  WIDTH  input real part
- in_im  in  WIDTH  input imaginary part
- tw_k  out  max(LOG2_D,1)  twiddle index k for W_{2D}^k; combinational from counter
- tw_re  in  TW_W  twiddle real part for tw_k, same cycle
- tw_im  in  TW_W  twiddle imaginary part for tw_k, same cycle
- out_valid  out  1  output sample valid
- out_re  out  WIDTH+1  output real part
- out_im  out  WIDTH+1  output imaginary part

Behaviour:
- Reset (asynchronous, active-low):
  - cnt = 0, primed = 0, delay line cleared to 0, pipeline valids 0.
  - out_valid = 0, out_re = 0, out_im = 0.
  - tw_k = 0 while in reset.
- cnt:
  - Counts accepted samples mod 2D. Advances only when in_valid = 1.
  - When in_valid & in_sof, the current sample is treated as cnt = 0, and cnt becomes 1 next cycle.
- Delay line:
  - D entries of WIDTH+1 bits, shift-register or circular buffer.
  - Advances (read oldest, write new) only on in_valid; holds contents across stalls.
  - Input x is sign-extended to WIDTH+1 bits.
- Phase A (cnt < D), per accepted sample:
  - Write x into the delay line.
  - Emit the popped value f (a stored difference) through the twiddle path with k = cnt[LOG2_D-1:0].
- Phase B (cnt >= D), per accepted sample:
  - Emit f + x with no twiddle.
  - Write f - x.
  - Both results are WIDTH+1 bits and exact; no overflow is possible since f is a sign-extended input in this phase.
- primed:
  - Set at the first accepted sample with cnt = D.
  - Phase A samples before primed = 1 are not emitted.
  - All later accepted samples are emitted.
- Pipeline, 2 stages, free-running with valid bits:
  - P1 registers the selected operand, twiddle, a bypass flag and a valid bit.
    - bypass = 1 in phase B, and in phase A when k = 0.
    - valid = in_valid & (primed | phase B).
  - P2 computes the result and registers out_*:
    - If bypass: output the operand unchanged.
    - Else: full-precision product re = a_re*w_re - a_im*w_im, im = a_re*w_im + a_im*w_re.
    - Then add 2^(TW_W-3), arithmetic shift right by (TW_W-2).
    - Then saturate to [-2^WIDTH, 2^WIDTH - 1].
- Latency: exactly 2 clk from an accepted input to its out_valid/out_*.
- Output hold: out_re/out_im hold their last value when out_valid = 0.
- in_sof mid-frame: counter resynchronises; delay line and primed are kept. Outputs of the interrupted frame are undefined but still flagged valid.
- Frame tail: the last frame's D differences emerge only as the next frame's phase-A samples are accepted; upstream feeds zeros to flush.
- tw_k while stalled: still reflects cnt; tw_re/tw_im are ignored unless sampled with a phase-A accept.

Test Plan:
1. Reset → out_valid = 0 and out_re = out_im = 0. Then rst_n high with in_valid = 0 → no output for 20 cycles.
2. D = 4, tw (16384, 0), re inputs 1..8 (im 0) with sof on 1, then 4 zeros → out_re = 6, 8, 10, 12, -4, -4, -4, -4. Each output is exactly 2 clk after inputs 5..12; im = 0 throughout.
3. Same frame with tw (0, -16384) for k ≠ 0 → diff outputs (-4, 0), (0, 4), (0, 4), (0, 4); the k = 0 entry bypasses the twiddle inputs.
4. Saturation: x0 = 32767 + 32767j, x4 = -32768 - 32768j, tw k = 1 = (16384, 16384) → sum (-1, -1). Diff 65535 + 65535j is stored; the multiply gives (0, 131070), saturated to (0, 65535).
5. Case 2 with random in_valid gaps (50% duty) → identical output value sequence; out_valid count = 8.
6. in_sof reasserted at sample 3, and separately rst_n pulsed low mid-frame → cnt restarts. After reset, the next 4 samples produce no output (primed cleared); no X on outputs.
